// File: rtl/masked_gf16_inv_if.sv
// Handshake bundle for masked_gf16_inv_pipe.
//   in_data/in_valid/in_ready : shared input nibbles, producer -> block
//   rnd                       : fresh randomness, sampled with stage-1 data
//   out_data/out_valid/out_ready : shared result nibbles, block -> consumer
// Packing for in_data, rnd and out_data: lane L share s at [(L*SHARES+s)*4 +: 4],
// bit 3 = X, bit 2 = Y, bit 1 = Z, bit 0 = V.
interface masked_gf16_inv_if #(
  parameter int unsigned SHARES = 5,
  parameter int unsigned LANES  = 2
);
  localparam int unsigned W = 4 * SHARES * LANES;

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rnd;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_data, in_valid, rnd, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Block side
  modport slave (
    input  in_data, in_valid, rnd, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/masked_gf16_inv_pipe.sv
// Two-stage masked nibble involution F over LANES independent lanes.
// Stage 1 evaluates non-complete share functions of the cubic map F: every
// monomial share product is owned by a component that never reads the share
// indices the product uses, so no component sees all shares of any variable.
// Stage 2 maps component m to output share m, optionally ring-refreshed.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : masked_gf16_inv_if.slave (in_data/in_valid/in_ready, rnd,
//           out_data/out_valid/out_ready)
// Optional feature macro: MASKED_INV_REMASK_EN -- when defined, output share s
// is XORed with rnd share s ^ rnd share (s+1) mod SHARES of the stage-1 sample.
module masked_gf16_inv_pipe #(
  parameter int unsigned SHARES = 5,
  parameter int unsigned LANES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  masked_gf16_inv_if.slave   bus
);

  localparam int unsigned W  = 4 * SHARES * LANES;
  localparam int unsigned LW = 4 * SHARES;
  localparam int unsigned IW = $clog2(SHARES);

  // Component that owns a share product over indices {i,j,k}: first index
  // after i (cyclically) not in the set, which keeps every component
  // non-complete and spreads terms over all components.
  function automatic logic [IW-1:0] owner(input int unsigned i,
                                          input int unsigned j,
                                          input int unsigned k);
    int unsigned c;
    int unsigned o;
    logic        found;
    found = 1'b0;
    o     = (i + 1) % SHARES;
    for (int unsigned d = 1; d < SHARES; d++) begin
      c = (i + d) % SHARES;
      if (!found && c != j && c != k) begin
        o     = c;
        found = 1'b1;
      end
    end
    return IW'(o);
  endfunction

  logic [W-1:0] s1_d;
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_d;
  logic [W-1:0] out_q;
  logic         s1_valid;
  logic         s1_valid_d;
  logic         out_valid;
  logic         out_valid_d;
  logic         load1;
  logic         load2;
  logic         in_ready_c;

  // Stage-1 share functions, one independent block per lane
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SHARES-1:0]      xs;
    logic [SHARES-1:0]      ys;
    logic [SHARES-1:0]      zs;
    logic [SHARES-1:0]      vs;
    logic [SHARES-1:0][3:0] comp;

    always_comb begin
      xs = '0;
      ys = '0;
      zs = '0;
      vs = '0;
      for (int unsigned s = 0; s < SHARES; s++) begin
        xs[s] = bus.in_data[(l*SHARES+s)*4 + 3];
        ys[s] = bus.in_data[(l*SHARES+s)*4 + 2];
        zs[s] = bus.in_data[(l*SHARES+s)*4 + 1];
        vs[s] = bus.in_data[(l*SHARES+s)*4 + 0];
      end
    end

    // Sum of all share products of each monomial, bit order {X',Y',Z',V'}
    always_comb begin
      comp = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
        // linear: X'=X+Y, Y'=Y, Z'=X+Y+Z, V'=Y+Z+V
        comp[owner(i, i, i)] ^= {xs[i] ^ ys[i],
                                 ys[i],
                                 xs[i] ^ ys[i] ^ zs[i],
                                 ys[i] ^ zs[i] ^ vs[i]};
        for (int unsigned j = 0; j < SHARES; j++) begin
          // quadratic: X'=XV, Y'=YZ+XV, Z'=YV, V'=XZ+XV+YZ
          comp[owner(i, j, j)] ^= {xs[i] & vs[j],
                                   (ys[i] & zs[j]) ^ (xs[i] & vs[j]),
                                   ys[i] & vs[j],
                                   (xs[i] & zs[j]) ^ (xs[i] & vs[j]) ^ (ys[i] & zs[j])};
          for (int unsigned k = 0; k < SHARES; k++) begin
            // cubic: X'=XYZ, Y'=XYZ+XYV, Z'=XYZ+XZV, V'=XYZ+XYV+XZV+YZV
            comp[owner(i, j, k)] ^= {xs[i] & ys[j] & zs[k],
                                     (xs[i] & ys[j] & zs[k]) ^ (xs[i] & ys[j] & vs[k]),
                                     (xs[i] & ys[j] & zs[k]) ^ (xs[i] & zs[j] & vs[k]),
                                     (xs[i] & ys[j] & zs[k]) ^ (xs[i] & ys[j] & vs[k]) ^
                                     (xs[i] & zs[j] & vs[k]) ^ (ys[i] & zs[j] & vs[k])};
          end
        end
      end
    end

    assign s1_d[l*LW +: LW] = comp;
  end

  // Handshake: a stage loads when its successor frees up or is empty
  assign in_ready_c = bus.out_ready | ~out_valid | ~s1_valid;
  assign bus.in_ready = in_ready_c;

  always_comb begin
    load2       = s1_valid & (bus.out_ready | ~out_valid);
    load1       = bus.in_valid & in_ready_c;
    s1_valid_d  = s1_valid;
    out_valid_d = out_valid;
    if (load2)         s1_valid_d  = 1'b0;
    if (load1)         s1_valid_d  = 1'b1;
    if (bus.out_ready) out_valid_d = 1'b0;
    if (load2)         out_valid_d = 1'b1;
  end

  // Valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= s1_valid_d;
      out_valid <= out_valid_d;
    end
  end

  // Stage-1 share registers only move on an accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (load1) begin
      s1_q <= s1_d;
    end
  end

`ifdef MASKED_INV_REMASK_EN
  logic [W-1:0] r1_q;
  logic [W-1:0] refresh;

  // Randomness captured alongside the stage-1 data it will refresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
    end else if (load1) begin
      r1_q <= bus.rnd;
    end
  end

  // Ring refresh: each rnd share is used twice per lane, so the lane sum is kept
  for (genvar l = 0; l < LANES; l++) begin : g_rf_lane
    for (genvar s = 0; s < SHARES; s++) begin : g_rf_share
      assign refresh[(l*SHARES+s)*4 +: 4] =
        r1_q[(l*SHARES+s)*4 +: 4] ^ r1_q[(l*SHARES+((s+1)%SHARES))*4 +: 4];
    end
  end

  assign s2_d = s1_q ^ refresh;
`else
  logic unused_rnd;
  assign unused_rnd = ^bus.rnd;
  assign s2_d = s1_q;
`endif

  // Stage-2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (load2) begin
      out_q <= s2_d;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_masked_gf16_inv_pipe.sv
// Self-checking bench for masked_gf16_inv_pipe (SHARES=5, LANES=2).
module tb_masked_gf16_inv_pipe;

  localparam int unsigned SHARES = 5;
  localparam int unsigned LANES  = 2;
  localparam int unsigned W      = 4 * SHARES * LANES;
  localparam int unsigned VW     = 4 * LANES;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  masked_gf16_inv_if #(.SHARES(SHARES), .LANES(LANES)) bus ();

  masked_gf16_inv_pipe #(.SHARES(SHARES), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] pend_q[$];
  logic [VW-1:0] exp_in_q[$];
  logic [VW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference F written directly from the polynomial definition
  function automatic logic [3:0] f_ref(input logic [3:0] a);
    logic x, y, z, v;
    {x, y, z, v} = a;
    return {(x&y&z) ^ (x&v) ^ x ^ y,
            (x&y&z) ^ (x&y&v) ^ (y&z) ^ (x&v) ^ y,
            (x&y&z) ^ (x&z&v) ^ (y&v) ^ x ^ y ^ z,
            (x&y&z) ^ (x&y&v) ^ (x&z&v) ^ (y&z&v) ^ (x&z) ^ (x&v) ^ (y&z) ^ y ^ z ^ v};
  endfunction

  function automatic logic [VW-1:0] f_lanes(input logic [VW-1:0] vals);
    logic [VW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*4 +: 4] = f_ref(vals[l*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] share_it(input logic [VW-1:0] vals);
    logic [W-1:0] d;
    logic [3:0]   acc;
    logic [3:0]   r;
    d = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = vals[l*4 +: 4];
      for (int s = 0; s < SHARES - 1; s++) begin
        r = 4'($urandom);
        d[(l*SHARES+s)*4 +: 4] = r;
        acc = acc ^ r;
      end
      d[(l*SHARES+SHARES-1)*4 +: 4] = acc;
    end
    return d;
  endfunction

  function automatic logic [3:0] lane_xor(input logic [W-1:0] d, input int l);
    logic [3:0] acc;
    acc = 4'h0;
    for (int s = 0; s < SHARES; s++) acc = acc ^ d[(l*SHARES+s)*4 +: 4];
    return acc;
  endfunction

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom(), $urandom()});
  endfunction

  // Streams pend_q through the block, checking results against exp_in_q order
  task automatic stream(input string tag, input int stall_at, input int stall_len,
                        output int n_out, output int gaps, output bit saw_block);
    int           cyc;
    int           total;
    bit           have;
    bit           started;
    logic [W-1:0] cur;
    logic [VW-1:0] e;
    cyc = 0; have = 0; started = 0; n_out = 0; gaps = 0; saw_block = 0;
    total = pend_q.size();
    cur = '0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (pend_q.size() > 0) begin
        if (!have) begin
          cur  = share_it(pend_q[0]);
          have = 1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = cur;
        bus.rnd      = rand_w();
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && !bus.in_ready) saw_block = 1;
      if (started && n_out < total && !bus.out_valid) gaps++;
      if (bus.out_valid && bus.out_ready) begin
        started = 1;
        if (exp_q.size() == 0) begin
          check({tag, "_spurious"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          for (int l = 0; l < LANES; l++)
            check($sformatf("%s_r%0d_l%0d", tag, n_out, l),
                  64'(lane_xor(bus.out_data, l)), 64'(e[l*4 +: 4]));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(exp_in_q.pop_front());
        void'(pend_q.pop_front());
        have = 0;
      end
      cyc++;
    end
    check({tag, "_timeout"}, 64'(pend_q.size() + exp_q.size()), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_one(input logic [W-1:0] d, input logic [W-1:0] r, output logic [W-1:0] o);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.rnd       = r;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.rnd       = rand_w();
    @(negedge clk);
    check("send_valid", 64'(bus.out_valid), 64'd1);
    o = bus.out_data;
  endtask

  logic [VW-1:0] dir_in  [5] = '{8'hA8, 8'h8A, 8'hF4, 8'h4F, 8'h10};
  logic [VW-1:0] dir_exp [5] = '{8'h8A, 8'hA8, 8'h4F, 8'hF4, 8'h10};

  initial begin
    int           n_out;
    int           gaps;
    bit           saw_block;
    logic [W-1:0] d;
    logic [W-1:0] oa;
    logic [W-1:0] ob;
    logic [W-1:0] rb;
    logic [VW-1:0] vals;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = rand_w();
    bus.rnd       = rand_w();
    bus.out_ready = 1'b1;

    // Reset state with in_valid held high
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // First transaction after release: exact two-cycle latency
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = share_it(8'h41);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    check("lat_lane0", 64'(lane_xor(bus.out_data, 0)), 64'h1);
    check("lat_lane1", 64'(lane_xor(bus.out_data, 1)), 64'hF);

    // Hand-computed vectors
    for (int i = 0; i < 5; i++) begin
      pend_q.push_back(dir_in[i]);
      exp_in_q.push_back(dir_exp[i]);
    end
    stream("dir", 1000, 0, n_out, gaps, saw_block);
    check("dir_count", 64'(n_out), 64'd5);

    // All 16 values per lane, back-to-back
    for (int v = 0; v < 16; v++) begin
      vals = {4'(15 - v), 4'(v)};
      pend_q.push_back(vals);
      exp_in_q.push_back(f_lanes(vals));
    end
    stream("exh", 1000, 0, n_out, gaps, saw_block);
    check("exh_count", 64'(n_out), 64'd16);
    check("exh_gaps",  64'(gaps),  64'd0);

    // Back-pressure mid-stream
    for (int i = 0; i < 10; i++) begin
      vals = VW'($urandom);
      pend_q.push_back(vals);
      exp_in_q.push_back(f_lanes(vals));
    end
    stream("bp", 4, 5, n_out, gaps, saw_block);
    check("bp_count", 64'(n_out), 64'd10);
    check("bp_in_ready_fell", 64'(saw_block), 64'd1);

    // Same sharing, two different rnd values
    d  = share_it(8'h3C);
    rb = '0;
    for (int i = 0; i < SHARES * LANES; i++) rb[i*4 +: 4] = 4'(i + 1);
    send_one(d, '0, oa);
    send_one(d, rb, ob);
    check("rf_a_lane0", 64'(lane_xor(oa, 0)), 64'(f_ref(4'hC)));
    check("rf_b_lane0", 64'(lane_xor(ob, 0)), 64'(f_ref(4'hC)));
    check("rf_b_lane1", 64'(lane_xor(ob, 1)), 64'(f_ref(4'h3)));
`ifdef MASKED_INV_REMASK_EN
    check("rf_shares_differ", 64'(oa != ob), 64'd1);
`else
    check("rf_rnd_ignored", 64'(ob), 64'(oa));
`endif

    // Reset with both stages full
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = share_it(8'h12);
    @(negedge clk);
    bus.in_data   = share_it(8'h34);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("mid_full_valid", 64'(bus.out_valid), 64'd1);
    check("mid_full_ready", 64'(bus.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data",  64'(bus.out_data),  64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid_no_stale_%0d", i), 64'(bus.out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
